// File: rtl/instr_issuer.sv
`default_nettype none
// ============================================================================
// Module      : instr_issuer
// Description : Mini-CPU instruction issuer; decodes one 16-bit instruction per
//               accept and drives the register-bank read/execute/write protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_issuer (
    input  logic        clk,
    input  logic        rst,
    input  logic        enviar,
    input  logic [15:0] instr,
    output logic [3:0]  mem_raddr1,
    output logic [3:0]  mem_raddr2,
    input  logic [15:0] mem_rdata1,
    input  logic [15:0] mem_rdata2,
    output logic        mem_we,
    output logic [3:0]  mem_waddr,
    output logic [15:0] mem_wdata,
    output logic        mem_clear,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [15:0] display_value,
    output logic        display_valid
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_EXEC  = 3'd2;
    localparam logic [2:0] c_WB    = 3'd3;
    localparam logic [2:0] c_CLR   = 3'd4;
    localparam logic [2:0] c_DISP  = 3'd5;

    localparam logic [2:0] c_OP_LOAD    = 3'b000;
    localparam logic [2:0] c_OP_ADD     = 3'b001;
    localparam logic [2:0] c_OP_ADDI    = 3'b010;
    localparam logic [2:0] c_OP_SUB     = 3'b011;
    localparam logic [2:0] c_OP_SUBI    = 3'b100;
    localparam logic [2:0] c_OP_MUL     = 3'b101;
    localparam logic [2:0] c_OP_CLEAR   = 3'b110;
    localparam logic [2:0] c_OP_DISPLAY = 3'b111;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [15:0] r_instr;
    logic [15:0] r_result;
    logic        r_ovf;
    logic [15:0] r_disp_value;
    logic        r_disp_valid;

    logic [2:0]  w_op;
    logic        w_is_rr;
    logic [3:0]  w_dst;
    logic [15:0] w_imm9;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_sum;
    logic [15:0] w_diff;
    logic signed [20:0] w_prod;
    logic        w_mul_ovf;
    logic [15:0] w_alu;
    logic        w_alu_ovf;
    logic        w_sets_ovf;

    // ------------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------------
    assign w_op    = r_instr[15:13];
    assign w_is_rr = (w_op == c_OP_ADD) || (w_op == c_OP_SUB);
    assign w_imm9  = {{7{r_instr[8]}}, r_instr[8:0]};

    always_comb begin
        w_dst = r_instr[8:5];
        if (w_op == c_OP_LOAD)
            w_dst = r_instr[12:9];
        else if (w_is_rr)
            w_dst = r_instr[4:1];
    end

    // ------------------------------------------------------------------------
    // ALU: operands arrive on the read ports during EXEC
    // ------------------------------------------------------------------------
    assign w_a    = mem_rdata1;
    assign w_b    = w_is_rr ? mem_rdata2 : {11'd0, r_instr[4:0]};
    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;
    // |src| * 31 fits in 21 signed bits, so the product is exact
    assign w_prod = $signed({{5{w_a[15]}}, w_a}) * $signed({16'd0, r_instr[4:0]});
    assign w_mul_ovf = ~((&w_prod[20:15]) | ~(|w_prod[20:15]));
    assign w_sets_ovf = (w_op == c_OP_ADD) || (w_op == c_OP_ADDI) ||
                        (w_op == c_OP_SUB) || (w_op == c_OP_SUBI) ||
                        (w_op == c_OP_MUL);

    always_comb begin
        w_alu     = w_a;
        w_alu_ovf = r_ovf;
        case (w_op)
            c_OP_ADD, c_OP_ADDI: begin
                w_alu     = w_sum;
                w_alu_ovf = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);
            end
            c_OP_SUB, c_OP_SUBI: begin
                w_alu     = w_diff;
                w_alu_ovf = (w_a[15] != w_b[15]) && (w_diff[15] != w_a[15]);
            end
            c_OP_MUL: begin
                w_alu     = w_prod[15:0];
                w_alu_ovf = w_mul_ovf;
            end
            default: begin
                w_alu     = w_a;
                w_alu_ovf = r_ovf;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (enviar) begin
                    case (instr[15:13])
                        c_OP_LOAD:  w_next = c_WB;
                        c_OP_CLEAR: w_next = c_CLR;
                        default:    w_next = c_FETCH;
                    endcase
                end
            end
            c_FETCH: w_next = c_EXEC;
            c_EXEC:  w_next = (w_op == c_OP_DISPLAY) ? c_DISP : c_WB;
            c_WB:    w_next = c_IDLE;
            c_CLR:   w_next = c_IDLE;
            c_DISP:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------------
    always_comb begin
        mem_raddr1 = 4'd0;
        mem_raddr2 = 4'd0;
        mem_we     = 1'b0;
        mem_waddr  = 4'd0;
        mem_wdata  = 16'd0;
        mem_clear  = 1'b0;
        done       = 1'b0;
        busy       = (r_state != c_IDLE);
        case (r_state)
            c_FETCH: begin
                mem_raddr1 = r_instr[12:9];
                mem_raddr2 = w_is_rr ? r_instr[8:5] : 4'd0;
            end
            c_WB: begin
                mem_we    = 1'b1;
                mem_waddr = w_dst;
                mem_wdata = (w_op == c_OP_LOAD) ? w_imm9 : r_result;
                done      = 1'b1;
            end
            c_CLR: begin
                mem_clear = 1'b1;
                done      = 1'b1;
            end
            c_DISP: begin
                done = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr      <= 16'd0;
            r_result     <= 16'd0;
            r_ovf        <= 1'b0;
            r_disp_value <= 16'd0;
            r_disp_valid <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && enviar)
                r_instr <= instr;
            if (r_state == c_EXEC) begin
                r_result <= w_alu;
                if (w_sets_ovf)
                    r_ovf <= w_alu_ovf;
            end
            if (r_state == c_CLR)
                r_disp_valid <= 1'b0;
            // for DISPLAY the ALU passes rdata1 through into r_result
            if (r_state == c_DISP) begin
                r_disp_value <= r_result;
                r_disp_valid <= 1'b1;
            end
        end
    end

    assign ovf           = r_ovf;
    assign display_value = r_disp_value;
    assign display_valid = r_disp_valid;

endmodule
`default_nettype wire

// File: tb/tb_instr_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_issuer
// Description : Scoreboard bench for instr_issuer with a register-bank responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enviar;
    logic [15:0] instr;
    logic [3:0]  mem_raddr1;
    logic [3:0]  mem_raddr2;
    logic [15:0] mem_rdata1;
    logic [15:0] mem_rdata2;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic        mem_clear;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] display_value;
    logic        display_valid;

    logic [15:0] regs [16];
    logic [19:0] sb [$];
    logic [19:0] sb_exp;
    int n_cmp = 0;
    int n_err = 0;
    int we_count = 0;
    int clr_count = 0;

    instr_issuer dut (
        .clk           (clk),
        .rst           (rst),
        .enviar        (enviar),
        .instr         (instr),
        .mem_raddr1    (mem_raddr1),
        .mem_raddr2    (mem_raddr2),
        .mem_rdata1    (mem_rdata1),
        .mem_rdata2    (mem_rdata2),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .mem_clear     (mem_clear),
        .busy          (busy),
        .done          (done),
        .ovf           (ovf),
        .display_value (display_value),
        .display_valid (display_valid)
    );

    always #5 clk = ~clk;

    // responder: read data one cycle after the address
    always @(posedge clk) begin
        mem_rdata1 <= regs[mem_raddr1];
        mem_rdata2 <= regs[mem_raddr2];
    end

    always @(negedge clk) begin
        if (mem_clear)
            clr_count++;
        if (mem_we) begin
            we_count++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", mem_waddr, mem_wdata);
            end else begin
                sb_exp = sb.pop_front();
                if ({mem_waddr, mem_wdata} !== sb_exp) begin
                    n_err++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_waddr, mem_wdata, sb_exp[19:16], sb_exp[15:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // accept edge k; returns at the start of cycle k+1
    task automatic issue(input logic [15:0] w);
        @(posedge clk);
        #1;
        instr  = w;
        enviar = 1'b1;
        @(posedge clk);
        #1;
        enviar = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(3);
        n_cmp++;
        if ({busy, done, mem_we, mem_clear, ovf, display_valid} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {busy, done, mem_we, mem_clear, ovf, display_valid});
        end
        n_cmp++;
        if ({mem_raddr1, mem_raddr2, mem_waddr, mem_wdata, display_value} !== 44'd0) begin
            n_err++;
            $display("FAIL reset_buses: got %h, required 0",
                     {mem_raddr1, mem_raddr2, mem_waddr, mem_wdata, display_value});
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_load;
        int w0;
        w0 = we_count;
        sb.push_back({4'd3, 16'hFFFB});
        issue({3'b000, 4'd3, 9'h1FB});
        n_cmp++;
        if ({mem_we, done, busy} !== 3'b111) begin
            n_err++;
            $display("FAIL load_wb: got we/done/busy=%b, required 111", {mem_we, done, busy});
        end
        step(1);
        n_cmp++;
        if ({mem_we, done, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL load_idle: got we/done/busy=%b, required 000", {mem_we, done, busy});
        end
        step(2);
        n_cmp++;
        if (we_count - w0 !== 1) begin
            n_err++;
            $display("FAIL load_we_count: got %0d, required 1", we_count - w0);
        end
    endtask

    task automatic test_alu(input string nm, input logic [15:0] w, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [3:0] d,
                            input logic [15:0] res, input logic eo);
        sb.push_back({d, res});
        issue(w);
        n_cmp++;
        if ({busy, mem_raddr1, mem_raddr2} !== {1'b1, s1, s2}) begin
            n_err++;
            $display("FAIL %s_fetch: got busy=%b ra1=%0d ra2=%0d, required busy=1 ra1=%0d ra2=%0d",
                     nm, busy, mem_raddr1, mem_raddr2, s1, s2);
        end
        step(1);
        n_cmp++;
        if ({mem_we, done} !== 2'b00) begin
            n_err++;
            $display("FAIL %s_exec: got we/done=%b, required 00", nm, {mem_we, done});
        end
        step(1);
        n_cmp++;
        if ({mem_we, done, ovf} !== {2'b11, eo}) begin
            n_err++;
            $display("FAIL %s_wb: got we/done/ovf=%b, required %b", nm, {mem_we, done, ovf}, {2'b11, eo});
        end
        step(1);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_busy_end: got %b, required 0", nm, busy);
        end
    endtask

    task automatic test_arith;
        regs[1] = 16'h7FFF;
        regs[2] = 16'h0001;
        test_alu("add", {3'b001, 4'd1, 4'd2, 4'd4, 1'b0}, 4'd1, 4'd2, 4'd4, 16'h8000, 1'b1);
        regs[5] = 16'h0005;
        test_alu("subi", {3'b100, 4'd5, 4'd9, 5'd3}, 4'd5, 4'd0, 4'd9, 16'h0002, 1'b0);
        regs[1] = 16'h8000;
        test_alu("sub", {3'b011, 4'd1, 4'd2, 4'd10, 1'b0}, 4'd1, 4'd2, 4'd10, 16'h7FFF, 1'b1);
        regs[3] = 16'hFFF0;
        test_alu("addi", {3'b010, 4'd3, 4'd11, 5'd31}, 4'd3, 4'd0, 4'd11, 16'h000F, 1'b0);
    endtask

    task automatic test_mul;
        regs[5] = 16'h1000;
        test_alu("mul_ok", {3'b101, 4'd5, 4'd6, 5'd3}, 4'd5, 4'd0, 4'd6, 16'h3000, 1'b0);
        regs[5] = 16'hFFFF;
        test_alu("mul_neg", {3'b101, 4'd5, 4'd6, 5'd31}, 4'd5, 4'd0, 4'd6, 16'hFFE1, 1'b0);
        regs[5] = 16'h4000;
        test_alu("mul_ovf", {3'b101, 4'd5, 4'd6, 5'd3}, 4'd5, 4'd0, 4'd6, 16'hC000, 1'b1);
    endtask

    task automatic test_display_clear;
        int c0;
        regs[7] = 16'h1234;
        issue({3'b111, 4'd7, 9'd0});
        step(2);
        n_cmp++;
        if ({done, mem_we, display_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL disp_done: got done/we/valid=%b, required 100", {done, mem_we, display_valid});
        end
        step(1);
        n_cmp++;
        if ({display_value, display_valid, busy} !== {16'h1234, 2'b10}) begin
            n_err++;
            $display("FAIL disp_value: got value=%h valid=%b busy=%b, required 1234 1 0",
                     display_value, display_valid, busy);
        end
        c0 = clr_count;
        issue({3'b110, 13'd0});
        n_cmp++;
        if ({mem_clear, done, mem_we} !== 3'b110) begin
            n_err++;
            $display("FAIL clr_pulse: got clear/done/we=%b, required 110", {mem_clear, done, mem_we});
        end
        step(1);
        n_cmp++;
        if ({mem_clear, display_valid, display_value, ovf} !== {2'b00, 16'h1234, 1'b1}) begin
            n_err++;
            $display("FAIL clr_after: got clear=%b valid=%b value=%h ovf=%b, required 0 0 1234 1",
                     mem_clear, display_valid, display_value, ovf);
        end
        step(2);
        n_cmp++;
        if (clr_count - c0 !== 1) begin
            n_err++;
            $display("FAIL clr_count: got %0d, required 1", clr_count - c0);
        end
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = we_count;
        for (int i = 0; i < 8; i++) begin
            instr  = {3'b000, i[3:0], 1'b1, 4'd0, i[3:0]};
            enviar = 1'b1;
            if (i % 2 == 0)
                sb.push_back({i[3:0], 16'hFF00 | 16'(i)});
            step(1);
        end
        enviar = 1'b0;
        step(3);
        n_cmp++;
        if (we_count - w0 !== 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d writes, required 4", we_count - w0);
        end
        regs[1] = 16'h7FFF;
        regs[2] = 16'h0001;
        w0 = we_count;
        sb.push_back({4'd4, 16'h8000});
        issue({3'b001, 4'd1, 4'd2, 4'd4, 1'b0});
        instr  = {3'b000, 4'd9, 9'd7};
        enviar = 1'b1;
        step(3);
        enviar = 1'b0;
        step(4);
        n_cmp++;
        if ({we_count - w0, busy} !== {32'd1, 1'b0}) begin
            n_err++;
            $display("FAIL busy_ignore: got %0d writes busy=%b, required 1 0", we_count - w0, busy);
        end
    endtask

    task automatic test_reset_abort;
        int w0;
        w0 = we_count;
        regs[1] = 16'h7FFF;
        regs[2] = 16'h0001;
        issue({3'b001, 4'd1, 4'd2, 4'd4, 1'b0});
        step(1);
        rst = 1'b1;
        step(1);
        n_cmp++;
        if ({busy, done, mem_we, mem_clear, ovf, display_valid, mem_raddr1, mem_raddr2,
             mem_waddr, mem_wdata, display_value} !== 50'd0) begin
            n_err++;
            $display("FAIL abort_outputs: got %h, required 0",
                     {busy, done, mem_we, mem_clear, ovf, display_valid, mem_raddr1, mem_raddr2,
                      mem_waddr, mem_wdata, display_value});
        end
        rst = 1'b0;
        step(5);
        n_cmp++;
        if (we_count - w0 !== 0) begin
            n_err++;
            $display("FAIL abort_no_write: got %0d writes, required 0", we_count - w0);
        end
        w0 = we_count;
        rst    = 1'b1;
        instr  = {3'b000, 4'd2, 9'd5};
        enviar = 1'b1;
        step(1);
        rst    = 1'b0;
        enviar = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_priority_busy: got %b, required 0", busy);
        end
        step(3);
        n_cmp++;
        if (we_count - w0 !== 0) begin
            n_err++;
            $display("FAIL rst_priority_write: got %0d writes, required 0", we_count - w0);
        end
    endtask

    initial begin
        enviar = 1'b0;
        instr  = 16'd0;
        rst    = 1'b1;
        for (int i = 0; i < 16; i++)
            regs[i] = 16'd0;
        test_reset;
        test_load;
        test_arith;
        test_mul;
        test_display_clear;
        test_back_to_back;
        test_reset_abort;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending writes, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
